// File: rtl/fir_buf_pkg.sv
// Shared types and helpers for the FIR output buffer and later output-side blocks.
// Build option: FIR_BUF_DROP_CNT_EN adds the saturating drop counter.
package fir_buf_pkg;

    localparam int unsigned FIR_IN_W  = 24;
    localparam int unsigned FIR_OUT_W = 16;
    localparam int unsigned FIR_DEPTH = 16;
    localparam int unsigned CALC_W    = 64;

    // Counter width holding 0..depth (one bit wider than the address).
    function automatic int unsigned ptrW(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptrW(FIR_DEPTH)-1:0] levelT;
    typedef logic signed [CALC_W-1:0]   calcT;

    // Round half-up by 'shift' bits, then saturate to a signed outW-bit range.
    function automatic calcT roundSat(input calcT x, input int unsigned shift,
                                      input int unsigned outW);
        calcT sum;
        calcT q;
        calcT maxV;
        calcT minV;
        if (shift == 0) begin
            return x;
        end
        sum  = x + (calcT'(1) <<< (shift - 1));
        q    = sum >>> shift;
        maxV = (calcT'(1) <<< (outW - 1)) - calcT'(1);
        minV = -(calcT'(1) <<< (outW - 1));
        if (q > maxV) begin
            return maxV;
        end
        if (q < minV) begin
            return minV;
        end
        return q;
    endfunction

endpackage

// File: rtl/fir_result_buffer_if.sv
// Stream interface between FIR result strobe, buffer, and consumer.
// Build option: FIR_BUF_DROP_CNT_EN adds drop_cnt.
interface fir_result_buffer_if import fir_buf_pkg::*; #(
    parameter int unsigned IN_W  = FIR_IN_W,
    parameter int unsigned OUT_W = FIR_OUT_W,
    parameter int unsigned DEPTH = FIR_DEPTH
);
    localparam int unsigned LVL_W = ptrW(DEPTH);

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             clr_ovf;
`ifdef FIR_BUF_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    modport master (
        output in_data, in_valid, out_ready, clr_ovf,
        input  out_data, out_valid, level, overflow
`ifdef FIR_BUF_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_ovf,
        output out_data, out_valid, level, overflow
`ifdef FIR_BUF_DROP_CNT_EN
        , output drop_cnt
`endif
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered head word; push into empty appears next cycle.
module fir_sync_fifo import fir_buf_pkg::*; #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic                      valid,
    output logic                      empty,
    output logic                      full,
    output logic [ptrW(DEPTH)-1:0]    level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wrCnt;
    logic [PW-1:0] rdCnt;
    logic [PW-1:0] wrCntN;
    logic [PW-1:0] rdCntN;
    logic [PW-1:0] levelN;
    logic [PW-1:0] remainC;
    logic          popEff;
    logic          pushEff;

    // Accepted push/pop and next pointer/level values.
    always_comb begin
        popEff  = pop && valid;
        pushEff = push && (!full || popEff);
        wrCntN  = wrCnt + PW'(pushEff);
        rdCntN  = rdCnt + PW'(popEff);
        levelN  = wrCntN - rdCntN;
        remainC = level - PW'(popEff);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (pushEff) begin
            mem[wrCnt[AW-1:0]] <= wdata;
        end
    end

    // Pointers, status flags and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrCnt <= '0;
            rdCnt <= '0;
            level <= '0;
            valid <= 1'b0;
            empty <= 1'b1;
            full  <= 1'b0;
            rdata <= '0;
        end else begin
            wrCnt <= wrCntN;
            rdCnt <= rdCntN;
            level <= levelN;
            valid <= (levelN != '0);
            empty <= (levelN == '0);
            full  <= (levelN == PW'(DEPTH));
            // Head only advances on pop or when nothing is presented.
            if (popEff || !valid) begin
                if (remainC == '0) begin
                    if (pushEff) begin
                        rdata <= wdata;
                    end
                end else begin
                    rdata <= mem[rdCntN[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/fir_result_buffer.sv
// FIR result capture: round/saturate to OUT_W, buffer in a FIFO, flag dropped samples.
// Build option: FIR_BUF_DROP_CNT_EN adds a saturating 16-bit drop counter on drop_cnt.
module fir_result_buffer import fir_buf_pkg::*; #(
    parameter int unsigned IN_W  = FIR_IN_W,
    parameter int unsigned OUT_W = FIR_OUT_W,
    parameter int unsigned DEPTH = FIR_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    fir_result_buffer_if.slave  bus
);
    localparam int unsigned SHIFT = IN_W - OUT_W;

    if (OUT_W > IN_W || OUT_W == 0) begin : gBadWidth
        $error("fir_result_buffer: OUT_W must be in 1..IN_W");
    end
    if (IN_W >= CALC_W) begin : gBadInW
        $error("fir_result_buffer: IN_W too wide for rounding helper");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("fir_result_buffer: DEPTH must be a power of two >= 2");
    end

    logic [OUT_W-1:0] roundC;
    logic [OUT_W-1:0] s1Data;
    logic             s1Valid;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pop;
    logic             drop;

    // Rounded and saturated version of the incoming FIR result.
    always_comb begin
        roundC = OUT_W'(roundSat(calcT'(signed'(bus.in_data)), SHIFT, OUT_W));
    end

    // Stage 1: register the rounded sample with its strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Data  <= '0;
        end else begin
            s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1Data <= roundC;
            end
        end
    end

    // Consumer transfer and lost-sample detection.
    always_comb begin
        pop  = bus.out_ready && !fifoEmpty;
        drop = s1Valid && fifoFull && !pop;
    end

    fir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1Valid),
        .pop   (pop),
        .wdata (s1Data),
        .rdata (bus.out_data),
        .valid (bus.out_valid),
        .empty (fifoEmpty),
        .full  (fifoFull),
        .level (bus.level)
    );

    // Sticky overflow flag; a drop outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.overflow <= 1'b0;
        end else if (drop) begin
            bus.overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            bus.overflow <= 1'b0;
        end
    end

`ifdef FIR_BUF_DROP_CNT_EN
    // Saturating count of dropped samples; clear plus drop leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.drop_cnt <= '0;
        end else if (drop) begin
            if (bus.clr_ovf) begin
                bus.drop_cnt <= 16'd1;
            end else if (bus.drop_cnt != 16'hFFFF) begin
                bus.drop_cnt <= bus.drop_cnt + 16'd1;
            end
        end else if (bus.clr_ovf) begin
            bus.drop_cnt <= '0;
        end
    end
`endif

endmodule
